lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
// - Multi-cycle load/store unit. Sits directly downstream of the control decoder and ALU.
// - Consumes the decoded memory controls: wren, store size, load type and a load-valid
//   qualifier, plus the ALU address and rs2 data.
// - Drives a request/acknowledge data-memory port, stalls the core until the access
//   completes, and returns the sign/zero-extended load word to writeback.
// PARAMETERS
// - TIMEOUT  default 16  max REQ cycles waiting for i_mem_ack before aborting (>=2)
// - AW       default 32  address width
// PORTS
// - i_clk         in   1   clock, rising edge
// - i_reset       in   1   reset, synchronous, active-high
// - i_rden        in   1   load instruction in execute (control decoder: opcode LOAD)
// - i_wren        in   1   store instruction in execute
// - i_slt_sl      in   3   store size: 000 SB, 001 SH, 010 SW
// - i_load_type   in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// - i_addr        in   AW  byte address (ALU result)
// - i_st_data     in   32  store data (rs2)
// - o_stall       out  1   hold PC and pipeline registers
// - o_ld_vld      out  1   o_ld_data valid this cycle (1-cycle pulse)
// - o_ld_data     out  32  extended load result
// - o_misaligned  out  1   1-cycle pulse: misaligned access rejected
// - o_mem_err     out  1   1-cycle pulse: access aborted by timeout
// - o_mem_req     out  1   memory request, held until ack
// - o_mem_we      out  1   1 = write
// - o_mem_addr    out  AW  word-aligned address, {addr[AW-1:2],2'b00}
// - o_mem_wdata   out  32  lane-replicated store data
// - o_mem_bmask   out  4   byte-lane write enables
// - i_mem_ack     in   1   memory completes the current request
// - i_mem_rdata   in   32  read word, valid with i_mem_ack
// BEHAVIOUR
// - FSM: IDLE -> REQ -> DONE -> IDLE.
// - Reset: state IDLE, timeout counter 0. Every output 0, o_ld_data 0.
// - Reset mid-access: o_mem_req drops at the next edge. Any pending ack is ignored.
// - Accept (IDLE & (i_rden|i_wren) & aligned):
//   - o_stall=1 combinationally in the same cycle.
//   - Register addr, we, mask, wdata, load_type.
//   - Go to REQ.
//   - i_rden&i_wren together: treated as a store.
// - Misaligned:
//   - Condition: halfword with addr[0]=1, or word with addr[1:0]!=0.
//   - No request is issued. o_misaligned=1 for that cycle, o_stall=0. State stays IDLE.
// - Store lanes:
//   - SB: mask 4'b0001<<addr[1:0], wdata={4{st[7:0]}}.
//   - SH: mask 4'b0011<<{addr[1],1'b0}, wdata={2{st[15:0]}}.
//   - SW: mask 4'b1111. Undefined size is treated as SW.
//   - Loads drive mask 0000 and we=0.
// - REQ:
//   - o_mem_req=1, o_stall=1. Address, we, mask and wdata stay stable until ack.
//   - On i_mem_ack: capture the extracted load data, go to DONE.
//   - Counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no
//     ack, go to DONE with the error flag set.
// - DONE:
//   - o_stall=0. The instruction retires this cycle. Always go to IDLE; no re-accept here.
//   - Load: o_ld_vld=1. o_ld_data = extended data, or 0 on timeout.
//   - Timeout: o_mem_err=1.
// - Latency: accept cycle C, ack at C+1 gives DONE at C+2. Minimum 2 stall cycles.
// - Load extract: byte lane addr[1:0], halfword lane addr[1].
//   - LB/LH sign-extend. LBU/LHU zero-extend. LW passes through.
// - i_mem_ack outside REQ is ignored.
// - o_ld_data holds its last value until the next capture.
// STRUCTURE
// - lsu_pkg holds: store-size and load-type localparams (shared with the control
//   decoder), state enum lsu_state_e {IDLE,REQ,DONE}, and the lane-mask constants.
// - Sub-module lsu_align: combinational mask, wdata replication, misalignment detection
//   and load extraction.
// - lsu_mem_ctrl holds the FSM, the capture registers and the timeout counter.
// TESTING
// - SW 0xDEADBEEF @0x100, ack at C+1:
//   - mask 1111, we=1, addr 0x100. Stall high C..C+1, low at C+2.
// - SB 0x000000A5 @0x103:
//   - mask 1000, wdata 0xA5A5A5A5.
// - LB @0x102, rdata 0x80FF7F00, ack delayed 3 cycles:
//   - req held 3 cycles. o_ld_vld with data 0xFFFFFFFF.
//   - Same access as LBU gives 0x000000FF.
// - LH @0x101:
//   - o_misaligned pulse, no o_mem_req, o_stall=0.
//   - LHU @0x102 with rdata 0x8001xxxx gives 0x00008001.
// - LW with no ack, TIMEOUT=16:
//   - 16 REQ cycles, then o_mem_err and o_ld_vld with data 0. Returns to IDLE.
// - Reset asserted in the 2nd REQ cycle, then ack:
//   - req=0 and all outputs 0 the next cycle. The ack is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit. The store-size and load-type codes
// match the control decoder's encodings.
package lsu_pkg;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte mask, store data replication,
// misalignment detection, and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  st_size,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  bmask,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ext_type,
  input  logic [1:0]  ext_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  // 0 = byte, 1 = halfword, 2 = word; unknown encodings fall back to word
  logic [1:0] size_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size_sel = 2'd2;
    if (is_store) begin
      if (st_size == SZ_B)      size_sel = 2'd0;
      else if (st_size == SZ_H) size_sel = 2'd1;
    end else begin
      if (load_type[1:0] == 2'b00)      size_sel = 2'd0;
      else if (load_type[1:0] == 2'b01) size_sel = 2'd1;
    end
  end

  always_comb begin
    bmask      = MASK_NONE;
    wdata      = st_data;
    misaligned = 1'b0;
    case (size_sel)
      2'd0: begin
        bmask = MASK_B << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      2'd1: begin
        bmask      = MASK_H << {addr_lo[1], 1'b0};
        wdata      = {2{st_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        bmask      = MASK_W;
        misaligned = |addr_lo;
      end
    endcase
    if (!is_store) bmask = MASK_NONE;
  end

  always_comb begin
    ld_byte = rdata[7:0];
    case (ext_addr_lo)
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      2'd3:    ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = ext_addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ld_data = rdata;
    case (ext_type)
      LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LT_LBU:  ld_data = {24'd0, ld_byte};
      LT_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: accepts one decoded memory op, issues a held
// request on the data-memory port, stalls the core, and retires in DONE.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_rden,
  input  logic          i_wren,
  input  logic [2:0]    i_slt_sl,
  input  logic [2:0]    i_load_type,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_st_data,
  output logic          o_stall,
  output logic          o_ld_vld,
  output logic [31:0]   o_ld_data,
  output logic          o_misaligned,
  output logic          o_mem_err,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output logic [1:0]    o_dbg_state
);

  // Handshake: o_mem_req rises after accept and stays high with stable
  // address/we/mask/wdata until the first cycle i_mem_ack is seen high in REQ.
  localparam int CW = $clog2(TIMEOUT);

  lsu_state_e state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [AW-3:0]   addr_q;
  logic [1:0]      lo_q;
  logic            we_q;
  logic [3:0]      mask_q;
  logic [31:0]     wdata_q;
  logic [2:0]      type_q;
  logic            err_q;
  logic [31:0]     ld_data_q;

  logic [3:0]  acc_mask;
  logic [31:0] acc_wdata;
  logic        acc_misaligned;
  logic [31:0] ext_data;
  logic        accept;
  logic        timeout_hit;

  lsu_align u_align (
    .is_store    (i_wren),
    .st_size     (i_slt_sl),
    .load_type   (i_load_type),
    .addr_lo     (i_addr[1:0]),
    .st_data     (i_st_data),
    .bmask       (acc_mask),
    .wdata       (acc_wdata),
    .misaligned  (acc_misaligned),
    .ext_type    (type_q),
    .ext_addr_lo (lo_q),
    .rdata       (i_mem_rdata),
    .ld_data     (ext_data)
  );

  assign accept      = (state_q == IDLE) && (i_rden || i_wren) && !acc_misaligned;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
      mask_q    <= '0;
      wdata_q   <= '0;
      type_q    <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= i_addr[AW-1:2];
        lo_q    <= i_addr[1:0];
        we_q    <= i_wren;
        mask_q  <= acc_mask;
        wdata_q <= acc_wdata;
        type_q  <= i_load_type;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == REQ) begin
        if (i_mem_ack) begin
          cnt_q <= '0;
          if (!we_q) ld_data_q <= ext_data;
        end else if (timeout_hit) begin
          cnt_q <= '0;
          err_q <= 1'b1;
          if (!we_q) ld_data_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    o_stall      = 1'b0;
    o_mem_req    = 1'b0;
    o_ld_vld     = 1'b0;
    o_mem_err    = 1'b0;
    o_misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rden || i_wren) begin
          if (acc_misaligned) begin
            o_misaligned = 1'b1;
          end else begin
            o_stall = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        if (i_mem_ack || timeout_hit) state_d = DONE;
      end
      DONE: begin
        o_ld_vld  = !we_q;
        o_mem_err = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_addr  = o_mem_req ? {addr_q, 2'b00} : '0;
  assign o_mem_wdata = o_mem_req ? wdata_q : '0;
  assign o_mem_bmask = o_mem_req ? mask_q : '0;
  assign o_ld_data   = ld_data_q;
  assign o_dbg_state = state_q;

endmodule
